// File: rtl/mem_stage_mc.sv
// mem_stage_mc: memory stage of the pipelined CPU.
//
// This block issues a request/ready/response access to a multi-cycle data
// memory. It stalls the upstream pipeline until the access completes and
// holds the load result in a register. It also forms the LLB/LHB byte-merged
// immediate, with optional forwarding of the merge source from WB.
//
// Parameters
//   DATA_W  datapath width (even, >= 4); H = DATA_W/2
//   ADDR_W  data-memory address width (<= DATA_W)
//   CNT_W   stall-cycle counter width
//
// Ports
//   clk, rst                        clock, async active-high reset
//   op, alu_out, RegData2           MEM-stage opcode, address/ALU result, store data
//   MemOp, MemWrite                 memory access / access is a store
//   ForwardImm, LdByte              merge source select / LLB(1) vs LHB(0)
//   imm_MEM, imm_WB                 immediates in MEM and WB
//   dmem_req, dmem_wr, dmem_addr,
//   dmem_wdata                      request side of the data-memory port
//   dmem_ready, dmem_rvalid,
//   dmem_rdata                      response side of the data-memory port
//   mem_out                         registered load result
//   imm_out, alu_imm                merged immediate / value for MEM/WB
//   stall                           freeze upstream stages this cycle
//   stall_cnt                       saturating count of stalled cycles
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access in flight; a request is presented while MemOp=1
// ST_WAIT | load accepted, waiting for dmem_rvalid
// ST_DONE | access complete; pipeline released for exactly one cycle
module mem_stage_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] RegData2,
  input  logic              MemOp,
  input  logic              MemWrite,
  input  logic              ForwardImm,
  input  logic              LdByte,
  input  logic [DATA_W-1:0] imm_MEM,
  input  logic [DATA_W-1:0] imm_WB,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] alu_imm,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int H = DATA_W / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  logic [DATA_W-1:0] merge_src;
  logic              byte_load;
  logic              unused_op0;

  // Reset gates both outputs so nothing is requested or frozen while held.
  assign stall    = ~rst & MemOp & (state != ST_DONE);
  assign dmem_req = ~rst & MemOp & (state == ST_IDLE);
  assign dmem_wr  = dmem_req & MemWrite;

  // Upstream is stalled while a request is pending, so these stay stable.
  assign dmem_addr  = alu_out[ADDR_W-1:0];
  assign dmem_wdata = RegData2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_out   <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MemOp && dmem_ready)
            state <= MemWrite ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            mem_out <= dmem_rdata;
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Byte merge: LLB keeps the upper half of the source, LHB keeps the lower.
  assign merge_src = ForwardImm ? imm_WB : RegData2;
  assign imm_out   = LdByte ? {merge_src[DATA_W-1:H], imm_MEM[H-1:0]}
                            : {imm_MEM[H-1:0], merge_src[H-1:0]};

  // Opcodes 1010 (LLB) and 1011 (LHB); op[0] does not matter here.
  assign byte_load  = op[3] & ~op[2] & op[1];
  assign unused_op0 = op[0];
  assign alu_imm    = byte_load ? imm_out : alu_out;

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic [15:0] alu_out, RegData2, imm_MEM, imm_WB, dmem_rdata;
  logic        MemOp, MemWrite, ForwardImm, LdByte, dmem_ready, dmem_rvalid;

  logic        dmem_req, dmem_wr, stall;
  logic [15:0] dmem_addr, dmem_wdata, mem_out, imm_out, alu_imm, stall_cnt;

  logic        s_req, s_wr, s_stall;
  logic [15:0] s_addr, s_wdata, s_mem_out, s_imm_out, s_alu_imm;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_mem;
  int          cnt16;
  int          cnt4;

  mem_stage_mc u_dut (
    .clk(clk), .rst(rst), .op(op), .alu_out(alu_out), .RegData2(RegData2),
    .MemOp(MemOp), .MemWrite(MemWrite), .ForwardImm(ForwardImm), .LdByte(LdByte),
    .imm_MEM(imm_MEM), .imm_WB(imm_WB),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_out(mem_out), .imm_out(imm_out), .alu_imm(alu_imm),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  mem_stage_mc #(.DATA_W(16), .ADDR_W(16), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .op(op), .alu_out(alu_out), .RegData2(RegData2),
    .MemOp(MemOp), .MemWrite(MemWrite), .ForwardImm(ForwardImm), .LdByte(LdByte),
    .imm_MEM(imm_MEM), .imm_WB(imm_WB),
    .dmem_req(s_req), .dmem_wr(s_wr), .dmem_addr(s_addr), .dmem_wdata(s_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_out(s_mem_out), .imm_out(s_imm_out), .alu_imm(s_alu_imm),
    .stall(s_stall), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall();
    if (cnt16 < 65535) cnt16++;
    if (cnt4 < 15) cnt4++;
  endtask

  // Starts in an IDLE cycle (1 time unit after a rising edge), runs one access
  // and returns 1 time unit after the DONE->IDLE edge.
  task automatic do_access(input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input int rdy_delay,
                           input int n_wait);
    logic [15:0] e;
    MemOp    = 1'b1;
    MemWrite = wr;
    alu_out  = addr;
    if (wr) RegData2 = data;
    for (int i = 0; i <= rdy_delay; i++) begin
      dmem_ready = (i == rdy_delay);
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1 || stall !== 1'b1 || dmem_wr !== wr) begin
        errors++;
        $display("FAIL req_phase cyc%0d req=%b stall=%b wr=%b need 1 1 %b", i, dmem_req, stall, dmem_wr, wr);
      end
      checks++;
      if (dmem_addr !== addr || (wr && dmem_wdata !== data)) begin
        errors++;
        $display("FAIL req_payload addr=%h wdata=%h need %h %h", dmem_addr, dmem_wdata, addr, data);
      end
      count_stall();
      step();
    end
    dmem_ready = 1'b0;
    if (!wr) begin
      for (int j = 0; j < n_wait; j++) begin
        dmem_rvalid = (j == n_wait - 1);
        if (dmem_rvalid) begin
          dmem_rdata = data;
          exp_q.push_back(data);
        end
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b1) begin
          errors++;
          $display("FAIL wait_phase cyc%0d req=%b stall=%b need 0 1", j, dmem_req, stall);
        end
        count_stall();
        step();
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = 16'h0000;
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL done_phase stall=%b req=%b need 0 0", stall, dmem_req);
    end
    if (!wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL load_result no expected entry, mem_out=%h", mem_out);
      end else begin
        e = exp_q.pop_front();
        exp_mem = e;
        if (mem_out !== e) begin
          errors++;
          $display("FAIL load_result mem_out=%h need %h", mem_out, e);
        end
      end
    end else begin
      checks++;
      if (mem_out !== exp_mem) begin
        errors++;
        $display("FAIL store_mem_out mem_out=%h need %h", mem_out, exp_mem);
      end
    end
    checks++;
    if (stall_cnt !== 16'(cnt16) || s_stall_cnt !== 4'(cnt4)) begin
      errors++;
      $display("FAIL stall_cnt got %0d/%0d need %0d/%0d", stall_cnt, s_stall_cnt, cnt16, cnt4);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MemOp = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_out !== 16'h0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_state req=%b stall=%b mem_out=%h cnt=%h need 0 0 0 0", dmem_req, stall, mem_out, stall_cnt);
    end
    MemOp = 1'b0;
    step();
    rst = 1'b0;
    exp_mem = 16'h0;
    cnt16 = 0;
    cnt4 = 0;
  endtask

  task automatic test_load();
    do_access(1'b0, 16'h0040, 16'hBEEF, 0, 3);
    MemOp = 1'b0;
  endtask

  task automatic test_store();
    do_access(1'b1, 16'h0010, 16'h1234, 2, 0);
    MemOp = 1'b0;
  endtask

  task automatic test_back_to_back();
    MemOp = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL nonmem_idle stall=%b req=%b need 0 0", stall, dmem_req);
    end
    step();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_out !== exp_mem) begin
      errors++;
      $display("FAIL stale_rvalid mem_out=%h need %h", mem_out, exp_mem);
    end
    step();
    do_access(1'b0, 16'h0100, 16'hA5A5, 0, 1);
    do_access(1'b0, 16'h0102, 16'h3C3C, 1, 2);
    MemOp = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 16'h0BAD;
    step();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_out !== exp_mem) begin
      errors++;
      $display("FAIL stale_rvalid_after mem_out=%h need %h", mem_out, exp_mem);
    end
    step();
  endtask

  task automatic test_merge();
    logic       fwd_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       ldb_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp_t[4] = '{16'h55AB, 16'h77AB, 16'hAB66, 16'hAB88};
    imm_MEM  = 16'h00AB;
    imm_WB   = 16'h5566;
    RegData2 = 16'h7788;
    alu_out  = 16'h1357;
    for (int k = 0; k < 4; k++) begin
      ForwardImm = fwd_t[k];
      LdByte     = ldb_t[k];
      op         = 4'b1010;
      #1;
      checks++;
      if (imm_out !== exp_t[k] || alu_imm !== exp_t[k]) begin
        errors++;
        $display("FAIL merge%0d imm_out=%h alu_imm=%h need %h", k, imm_out, alu_imm, exp_t[k]);
      end
      op = 4'b1011;
      #1;
      checks++;
      if (alu_imm !== exp_t[k]) begin
        errors++;
        $display("FAIL merge_op1011_%0d alu_imm=%h need %h", k, alu_imm, exp_t[k]);
      end
      op = 4'b0010;
      #1;
      checks++;
      if (alu_imm !== 16'h1357) begin
        errors++;
        $display("FAIL merge_op0010_%0d alu_imm=%h need 1357", k, alu_imm);
      end
    end
    op = 4'b0000;
  endtask

  task automatic test_reset_in_wait();
    MemOp = 1'b1;
    MemWrite = 1'b0;
    alu_out = 16'h0080;
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || mem_out !== 16'h0 || stall_cnt !== 16'h0 || s_stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_in_wait stall=%b req=%b mem_out=%h cnt=%h/%h need 0 0 0 0/0", stall, dmem_req, mem_out, stall_cnt, s_stall_cnt);
    end
    step();
    rst = 1'b0;
    MemOp = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 16'hFFFF;
    step();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_out !== 16'h0 || stall !== 1'b0 || stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_rvalid mem_out=%h stall=%b cnt=%h need 0 0 0", mem_out, stall, stall_cnt);
    end
    step();
    exp_mem = 16'h0;
    cnt16 = 0;
    cnt4 = 0;
    exp_q.delete();
    MemOp = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset req=%b need 1", dmem_req);
    end
  endtask

  task automatic test_saturation();
    do_access(1'b0, 16'h0200, 16'h4242, 0, 20);
    MemOp = 1'b0;
    checks++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd21) begin
      errors++;
      $display("FAIL stall_cnt_saturate got %h/%0d need F/21", s_stall_cnt, stall_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    op = 4'b0000;
    alu_out = '0;
    RegData2 = '0;
    imm_MEM = '0;
    imm_WB = '0;
    dmem_rdata = '0;
    MemOp = 1'b0;
    MemWrite = 1'b0;
    ForwardImm = 1'b0;
    LdByte = 1'b0;
    dmem_ready = 1'b0;
    dmem_rvalid = 1'b0;
    exp_mem = '0;
    cnt16 = 0;
    cnt4 = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_merge();
    test_reset_in_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
